// File: rtl/flash_program_ctrl_if.sv
// flash_program_ctrl_if: handshake, Rx FIFO and ASMI command bundle for the flash programming controller
interface flash_program_ctrl_if #(
  parameter int ADDR_W  = 24,
  parameter int USED_W  = 10,
  parameter int BLOCK_W = 14
);
  logic               erase, erase_ack, erase_done, erase_done_ack;
  logic [USED_W-1:0]  fifo_used;
  logic [7:0]         fifo_data;
  logic               rdreq;
  logic [BLOCK_W-1:0] num_blocks;
  logic               send_more, send_more_ack, nconfig, error;
  logic [ADDR_W-1:0]  flash_addr;
  logic               flash_sector_erase, flash_wren, flash_write, flash_shift_bytes;
  logic [7:0]         flash_datain;
  logic               flash_busy;
  modport master (
    input  erase, erase_done_ack, fifo_used, fifo_data, num_blocks, send_more_ack, flash_busy,
    output erase_ack, erase_done, rdreq, send_more, nconfig, error, flash_addr,
           flash_sector_erase, flash_wren, flash_write, flash_shift_bytes, flash_datain
  );
  modport slave (
    output erase, erase_done_ack, fifo_used, fifo_data, num_blocks, send_more_ack, flash_busy,
    input  erase_ack, erase_done, rdreq, send_more, nconfig, error, flash_addr,
           flash_sector_erase, flash_wren, flash_write, flash_shift_bytes, flash_datain
  );
endinterface

// File: rtl/flash_program_ctrl.sv
// flash_program_ctrl: erases the update region, streams FIFO pages into ASMI flash, then triggers reconfiguration
module flash_program_ctrl #(
  parameter int                ADDR_W         = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 24'h100000,
  parameter logic [ADDR_W-1:0] SECTOR_SIZE    = 24'h040000,
  parameter int                NUM_SECTORS    = 8,
  parameter int                PAGE_BYTES     = 256,
  parameter int                USED_W         = 10,
  parameter int                BLOCK_W        = 14,
  parameter int                BUSY_TIMEOUT   = 2**26,
  parameter int                RECONFIG_DELAY = 25000000,
  parameter int                BIT_REVERSE    = 1
) (
  input logic clk,
  input logic rst,
  flash_program_ctrl_if.master f
);
  localparam int SEC_W  = NUM_SECTORS > 1 ? $clog2(NUM_SECTORS) : 1;
  localparam int BYTE_W = PAGE_BYTES > 1 ? $clog2(PAGE_BYTES) : 1;
  localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam int DLY_W  = $clog2(RECONFIG_DELAY + 1);
  localparam logic [ADDR_W:0] END_ADDR = (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(NUM_SECTORS * SECTOR_SIZE);
  typedef enum logic [3:0] {
    IDLE, ERASE_CMD, ERASE_WAIT, ERASE_DONE, LOAD, PROG, PAGE_WAIT, FINAL_HS, RECONFIG, ERROR
  } state_t;
  state_t             state;
  logic [SEC_W-1:0]   sector;
  logic [BYTE_W-1:0]  byte_cnt;
  logic [BLOCK_W-1:0] page, blocks;
  logic [TO_W-1:0]    tcnt;
  logic [DLY_W-1:0]   dly;
  logic [7:0]         rev;
  logic [ADDR_W:0]    next_addr;
  logic               fifo_ready, busy_wait, timeout, load_ok, overflow;
  genvar i;
  for (i = 0; i < 8; i++) begin : g_rev
    assign rev[i] = f.fifo_data[7-i];
  end
  assign f.flash_datain = f.flash_shift_bytes ? (BIT_REVERSE != 0 ? rev : f.fifo_data) : 8'h00;
  assign next_addr  = {1'b0, f.flash_addr} + (ADDR_W+1)'(PAGE_BYTES);
  assign fifo_ready = f.fifo_used >= USED_W'(PAGE_BYTES);
  assign busy_wait  = (state == ERASE_WAIT || state == PAGE_WAIT || state == RECONFIG) && f.flash_busy;
  assign timeout    = busy_wait && tcnt == TO_W'(BUSY_TIMEOUT - 1);
  assign load_ok    = state == PAGE_WAIT && page != blocks && !f.flash_busy && fifo_ready && !f.send_more;
  // Region end is checked before the next page's address is committed, so flash_addr never leaves the region.
  assign overflow   = load_ok && next_addr >= END_ADDR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      f.erase_ack          <= 1'b0;
      f.erase_done         <= 1'b0;
      f.rdreq              <= 1'b0;
      f.send_more          <= 1'b0;
      f.nconfig            <= 1'b0;
      f.error              <= 1'b0;
      f.flash_addr         <= BASE_ADDR;
      f.flash_sector_erase <= 1'b0;
      f.flash_wren         <= 1'b0;
      f.flash_write        <= 1'b0;
      f.flash_shift_bytes  <= 1'b0;
      sector               <= '0;
      byte_cnt             <= '0;
      page                 <= '0;
      blocks               <= '0;
      tcnt                 <= '0;
      dly                  <= '0;
    end else begin
      tcnt <= busy_wait ? tcnt + 1'b1 : '0;
      if (timeout || overflow) begin
        state                <= ERROR;
        f.error              <= 1'b1;
        f.erase_ack          <= 1'b0;
        f.rdreq              <= 1'b0;
        f.send_more          <= 1'b0;
        f.flash_sector_erase <= 1'b0;
        f.flash_wren         <= 1'b0;
        f.flash_write        <= 1'b0;
        f.flash_shift_bytes  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (f.erase) begin
              state                <= ERASE_CMD;
              f.erase_ack          <= 1'b1;
              f.flash_wren         <= 1'b1;
              f.flash_sector_erase <= 1'b1;
            end else if (fifo_ready && f.num_blocks != '0) begin
              state               <= LOAD;
              blocks              <= f.num_blocks;
              page                <= '0;
              byte_cnt            <= '0;
              f.rdreq             <= 1'b1;
              f.flash_shift_bytes <= 1'b1;
              f.flash_wren        <= 1'b1;
            end
          end
          ERASE_CMD: begin
            state                <= ERASE_WAIT;
            f.erase_ack          <= 1'b0;
            f.flash_wren         <= 1'b0;
            f.flash_sector_erase <= 1'b0;
          end
          ERASE_WAIT: begin
            if (!f.flash_busy && sector != SEC_W'(NUM_SECTORS - 1)) begin
              state                <= ERASE_CMD;
              sector               <= sector + 1'b1;
              f.flash_addr         <= f.flash_addr + SECTOR_SIZE;
              f.erase_ack          <= 1'b1;
              f.flash_wren         <= 1'b1;
              f.flash_sector_erase <= 1'b1;
            end else if (!f.flash_busy) begin
              state        <= ERASE_DONE;
              sector       <= '0;
              f.flash_addr <= BASE_ADDR;
              f.erase_done <= 1'b1;
            end
          end
          ERASE_DONE: begin
            if (f.erase_done_ack) begin
              state        <= IDLE;
              f.erase_done <= 1'b0;
            end
          end
          LOAD: begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == BYTE_W'(PAGE_BYTES - 1)) begin
              state               <= PROG;
              page                <= page + 1'b1;
              f.rdreq             <= 1'b0;
              f.flash_shift_bytes <= 1'b0;
              f.flash_write       <= 1'b1;
              f.send_more         <= 1'b1;
            end
          end
          PROG: begin
            state         <= PAGE_WAIT;
            f.flash_write <= 1'b0;
            f.flash_wren  <= 1'b0;
          end
          PAGE_WAIT: begin
            if (page == blocks) state <= FINAL_HS;
            else begin
              if (f.send_more_ack) f.send_more <= 1'b0;
              if (load_ok) begin
                state               <= LOAD;
                byte_cnt            <= '0;
                f.flash_addr        <= next_addr[ADDR_W-1:0];
                f.rdreq             <= 1'b1;
                f.flash_shift_bytes <= 1'b1;
                f.flash_wren        <= 1'b1;
              end
            end
          end
          FINAL_HS: begin
            if (f.send_more_ack) begin
              state       <= RECONFIG;
              f.send_more <= 1'b0;
              dly         <= '0;
            end
          end
          RECONFIG: begin
            if (dly != DLY_W'(RECONFIG_DELAY)) dly <= dly + 1'b1;
            else if (!f.flash_busy) f.nconfig <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_flash_program_ctrl.sv
// tb_flash_program_ctrl: directed checks of erase, paging, threshold, reconfig, timeout, reset and overflow
module tb_flash_program_ctrl;
  logic clk = 1'b0, rst = 1'b1, rst_b = 1'b1, busy_force = 1'b0, prev_rd = 1'b0, b_prev = 1'b0;
  int total = 0, passed = 0;
  int busy_cnt = 0, se_n = 0, wr_n = 0, nb = 0, din_bad = 0, b_nb = 0, w0;
  logic [23:0] se_addr [8];
  logic [23:0] bst_addr [8];
  int blen [8];
  logic [7:0] first_din = 8'h00, a_ptr = 8'h00, b_ptr = 8'h00;

  flash_program_ctrl_if #(.ADDR_W(24), .USED_W(10), .BLOCK_W(14)) a ();
  flash_program_ctrl_if #(.ADDR_W(24), .USED_W(10), .BLOCK_W(14)) b ();

  flash_program_ctrl #(.NUM_SECTORS(4), .PAGE_BYTES(256), .BUSY_TIMEOUT(50), .RECONFIG_DELAY(100))
    dut_a (.clk(clk), .rst(rst), .f(a));
  flash_program_ctrl #(.NUM_SECTORS(1), .SECTOR_SIZE(24'h000040), .PAGE_BYTES(16), .BUSY_TIMEOUT(50), .RECONFIG_DELAY(100))
    dut_b (.clk(clk), .rst(rst_b), .f(b));

  always #5 clk = ~clk;

  assign a.flash_busy = busy_force | (busy_cnt != 0);
  assign a.fifo_data  = a_ptr + 8'd1;
  assign b.flash_busy = 1'b0;
  assign b.fifo_data  = b_ptr;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    return {<<{x}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    if (a.rdreq) a_ptr <= a_ptr + 8'd1;
    if (b.rdreq) b_ptr <= b_ptr + 8'd1;
  end

  // Flash model: an erase keeps the part busy 10 cycles, a page write 5 cycles.
  always @(negedge clk) begin
    if (a.flash_sector_erase) begin
      if (se_n < 8) se_addr[se_n] = a.flash_addr;
      se_n++;
    end
    if (a.flash_write) wr_n++;
    if (a.rdreq) begin
      if (!prev_rd && nb < 8) begin
        bst_addr[nb] = a.flash_addr;
        blen[nb] = 0;
        if (nb == 0) first_din = a.flash_datain;
      end
      if (nb < 8) blen[nb]++;
      if (a.flash_datain !== rev8(a.fifo_data)) din_bad++;
    end else if (prev_rd) nb++;
    prev_rd = a.rdreq;
    busy_cnt = a.flash_sector_erase ? 10 : a.flash_write ? 5 : (busy_cnt != 0 ? busy_cnt - 1 : 0);
    b.send_more_ack = b.send_more;
    if (b.rdreq && !b_prev) b_nb++;
    b_prev = b.rdreq;
  end

  initial begin
    a.erase = 1'b0; a.erase_done_ack = 1'b0; a.fifo_used = '0; a.num_blocks = '0; a.send_more_ack = 1'b0;
    b.erase = 1'b0; b.erase_done_ack = 1'b0; b.fifo_used = '0; b.num_blocks = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(a.flash_addr), 32'h100000);
    check("rst_outs", 32'({a.erase_ack, a.erase_done, a.rdreq, a.send_more, a.nconfig, a.error, a.flash_sector_erase,
                           a.flash_wren, a.flash_write, a.flash_shift_bytes, a.flash_datain}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    // erase four sectors
    a.erase = 1'b1;
    for (int i = 0; i < 20 && a.erase_ack !== 1'b1; i++) @(negedge clk);
    check("erase_ack", 32'(a.erase_ack), 32'h1);
    a.erase = 1'b0;
    for (int i = 0; i < 500 && a.erase_done !== 1'b1; i++) @(negedge clk);
    check("erase_done_set", 32'(a.erase_done), 32'h1);
    check("erase_pulses", 32'(se_n), 32'd4);
    check("se_addr0", 32'(se_addr[0]), 32'h100000);
    check("se_addr1", 32'(se_addr[1]), 32'h140000);
    check("se_addr2", 32'(se_addr[2]), 32'h180000);
    check("se_addr3", 32'(se_addr[3]), 32'h1C0000);
    check("erase_addr_back", 32'(a.flash_addr), 32'h100000);
    repeat (5) @(negedge clk);
    check("erase_done_hold", 32'(a.erase_done), 32'h1);
    a.erase_done_ack = 1'b1;
    @(negedge clk);
    check("erase_done_clear", 32'(a.erase_done), 32'h0);
    a.erase_done_ack = 1'b0;
    // FIFO threshold
    a.num_blocks = 14'd3;
    a.fifo_used = 10'd255;
    repeat (5) @(negedge clk);
    check("below_threshold", 32'(a.rdreq), 32'h0);
    a.fifo_used = 10'd256;
    @(negedge clk);
    check("threshold_start", 32'(a.rdreq), 32'h1);
    a.fifo_used = 10'd1000;
    // three pages, the last one handshaken by hand
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1000 && a.send_more !== 1'b1; i++) @(negedge clk);
      check("send_more_rise", 32'(a.send_more), 32'h1);
      if (p < 2) begin
        a.send_more_ack = 1'b1;
        for (int i = 0; i < 20 && a.send_more !== 1'b0; i++) @(negedge clk);
        a.send_more_ack = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    check("final_hold", 32'(a.send_more), 32'h1);
    a.send_more_ack = 1'b1;
    @(negedge clk);
    check("final_ack_fall", 32'(a.send_more), 32'h0);
    a.send_more_ack = 1'b0;
    repeat (90) @(negedge clk);
    busy_force = 1'b1;
    repeat (20) @(negedge clk);
    check("nconfig_wait_busy", 32'(a.nconfig), 32'h0);
    busy_force = 1'b0;
    @(negedge clk);
    check("nconfig_rise", 32'(a.nconfig), 32'h1);
    check("bursts", 32'(nb), 32'd3);
    check("blen0", 32'(blen[0]), 32'd256);
    check("blen1", 32'(blen[1]), 32'd256);
    check("blen2", 32'(blen[2]), 32'd256);
    check("page_addr0", 32'(bst_addr[0]), 32'h100000);
    check("page_addr1", 32'(bst_addr[1]), 32'h100100);
    check("page_addr2", 32'(bst_addr[2]), 32'h100200);
    check("first_datain", 32'(first_din), 32'h80);
    check("datain_reverse", 32'(din_bad), 32'd0);
    check("write_pulses", 32'(wr_n), 32'd3);
    // busy stuck high during erase
    rst = 1'b1;
    @(negedge clk);
    check("nconfig_reset", 32'(a.nconfig), 32'h0);
    rst = 1'b0;
    busy_force = 1'b1;
    a.erase = 1'b1;
    for (int i = 0; i < 20 && a.erase_ack !== 1'b1; i++) @(negedge clk);
    a.erase = 1'b0;
    repeat (50) @(negedge clk);
    check("timeout_before", 32'(a.error), 32'h0);
    @(negedge clk);
    check("timeout_error", 32'(a.error), 32'h1);
    check("timeout_strobes", 32'({a.flash_sector_erase, a.flash_wren, a.flash_write, a.flash_shift_bytes,
                                  a.rdreq, a.send_more}), 32'h0);
    busy_force = 1'b0;
    repeat (5) @(negedge clk);
    check("error_sticky", 32'(a.error), 32'h1);
    // reset in the middle of a page load
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a.num_blocks = 14'd2;
    for (int i = 0; i < 20 && a.rdreq !== 1'b1; i++) @(negedge clk);
    w0 = wr_n;
    repeat (100) @(negedge clk);
    check("mid_load", 32'(a.rdreq), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_outs", 32'({a.erase_ack, a.erase_done, a.rdreq, a.send_more, a.nconfig, a.error, a.flash_sector_erase,
                             a.flash_wren, a.flash_write, a.flash_shift_bytes, a.flash_datain}), 32'h0);
    check("abort_addr", 32'(a.flash_addr), 32'h100000);
    @(negedge clk);
    rst = 1'b0;
    a.num_blocks = 14'd0;
    repeat (20) @(negedge clk);
    check("zero_blocks_idle", 32'(a.rdreq), 32'h0);
    check("abort_no_write", 32'(wr_n), 32'(w0));
    // region overflow: 64-byte region holds four 16-byte pages, fifth is refused
    b.fifo_used = 10'd100;
    b.num_blocks = 14'd5;
    rst_b = 1'b0;
    for (int i = 0; i < 1000 && b.error !== 1'b1; i++) @(negedge clk);
    check("overflow_error", 32'(b.error), 32'h1);
    check("overflow_bursts", 32'(b_nb), 32'd4);
    check("overflow_addr", 32'(b.flash_addr), 32'h100030);
    check("overflow_quiet", 32'({b.rdreq, b.send_more, b.flash_wren, b.flash_write}), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/flash_program_ctrl.md
# flash_program_ctrl

Parametrised EPCS/ASMI flash programming controller for remote firmware update. It erases a configurable run of sectors, then streams pages of PC-supplied bytes from the Rx FIFO into the serial-flash page buffer. It handshakes progress back to the Tx side and pulses NCONFIG to reload the FPGA after the final page. Unlike the previous fixed-geometry interface, it drives an external ASMI-compatible port, has busy-timeout and region-overflow error detection, and uses a proper FIFO threshold.

## Interface
- ADDR_W, 24: flash address width.
- BASE_ADDR, 24'h100000: first byte of the update region (sector aligned).
- SECTOR_SIZE, 24'h040000: bytes per erase sector.
- NUM_SECTORS, 8: sectors erased per erase command; region = NUM_SECTORS*SECTOR_SIZE.
- PAGE_BYTES, 256: bytes per program page (power of two, ≤ 2^USED_W − 1).
- USED_W, 10: width of fifo_used.
- BLOCK_W, 14: width of num_blocks/page counter.
- BUSY_TIMEOUT, 2^26: max consecutive flash_busy cycles before error.
- RECONFIG_DELAY, 25000000: cycles from final handshake to NCONFIG.
- BIT_REVERSE, 1: 1 = flash_datain is fifo_data bit-reversed (bit 7↔0); 0 = pass-through.
- clock  in  1  single clock; every register updates on its rising edge.
- reset  in  1  asynchronous, active-high; forces the IDLE state and reset values.
- erase  in  1  level request to erase region.
- erase_ACK  out  1  high in ERASE_CMD states (command seen).
- erase_done  out  1  high from ERASE_DONE until erase_done_ACK.
- erase_done_ACK  in  1  Tx has reported erase completion.
- fifo_used  in  USED_W  Rx FIFO fill level.
- fifo_data  in  8  Rx FIFO show-ahead output byte.
- rdreq  out  1  FIFO pop, one byte per high cycle.
- num_blocks  in  BLOCK_W  total pages in this update; sampled on leaving IDLE into LOAD.
- send_more  out  1  request next page from PC; held until send_more_ACK.
- send_more_ACK  in  1  Tx has sent the request.
- NCONFIG  out  1  reconfiguration trigger; once set, stays high until reset.
- error  out  1  sticky fault (timeout or overflow).
- flash_addr  out  ADDR_W, flash_sector_erase out 1, flash_wren out 1, flash_write out 1, flash_shift_bytes out 1, flash_datain out 8  ASMI command port.
- flash_busy  in  1  ASMI busy.

## Operation
- Reset values: all outputs 0; flash_addr = BASE_ADDR; page counter 0; delay/timeout counters 0.
- IDLE: if erase → ERASE_CMD (erase has priority); else if fifo_used ≥ PAGE_BYTES and num_blocks ≠ 0 → LOAD; else stay. num_blocks = 0 never starts programming.
- ERASE_CMD (1 cycle): flash_wren = flash_sector_erase = 1, erase_ACK = 1 → ERASE_WAIT.
- ERASE_WAIT: wren/sector_erase = 0. While flash_busy, stay. On !flash_busy: if sector index < NUM_SECTORS−1, flash_addr += SECTOR_SIZE → ERASE_CMD; else flash_addr = BASE_ADDR → ERASE_DONE.
- ERASE_DONE: erase_done = 1 until erase_done_ACK → IDLE.
- LOAD: exactly PAGE_BYTES cycles with rdreq = flash_shift_bytes = flash_wren = 1 and flash_datain = (reversed) fifo_data in the same cycle. Then page++ → PROG.
- PROG (1 cycle): flash_write = 1, send_more = 1 → PAGE_WAIT.
- PAGE_WAIT: wren/write = 0; send_more cleared on send_more_ACK. If page == num_blocks → FINAL_HS with send_more = 1. Else when !flash_busy, fifo_used ≥ PAGE_BYTES, and send_more = 0: flash_addr += PAGE_BYTES → LOAD.
- FINAL_HS: clear send_more on send_more_ACK → RECONFIG.
- RECONFIG: count to RECONFIG_DELAY, then set NCONFIG when !flash_busy; remain.
- Overflow: if a next-page address would reach BASE_ADDR + region, → ERROR instead of LOAD.
- Timeout: counter increments each cycle flash_busy is sampled high in ERASE_WAIT/PAGE_WAIT/RECONFIG, clears when low; reaching BUSY_TIMEOUT → ERROR.
- ERROR: all flash strobes, rdreq, send_more 0; error = 1; held until reset.
- Arithmetic: flash_addr is modulo 2^ADDR_W (overflow check prevents wrap in use); page counter BLOCK_W bits.
- Reset mid-operation: abort immediately; a partially loaded page is discarded (flash_write never asserted).

## Timing
- Erase: ERASE_CMD strobe width 1 cycle; next sector command ≥1 cycle after busy falls.
- Page: IDLE→first rdreq 1 cycle; rdreq burst exactly PAGE_BYTES contiguous cycles; flash_write 1 cycle after last shift; send_more rises with flash_write.
- send_more falls the cycle after send_more_ACK is sampled high.
- NCONFIG ≥ RECONFIG_DELAY cycles after FINAL_HS exit.

## Test plan
- Erase, NUM_SECTORS=4, busy 10 cycles each → 4 sector_erase pulses at 0x100000, 0x140000, 0x180000, 0x1C0000; erase_done until ACK.
- Program num_blocks=3, FIFO pre-filled 0x01..: 3 bursts of 256 rdreq; flash_addr 0x100000/0x100100/0x100200; datain for 0x01 = 0x80.
- fifo_used=255 (PAGE_BYTES=256) → no rdreq; raise to 256 → burst starts next cycle.
- Final page: send_more held until ACK, NCONFIG rises RECONFIG_DELAY (set 100) cycles later, not while busy.
- flash_busy stuck high, BUSY_TIMEOUT=50 → error = 1 at cycle 50, strobes 0; reset mid-LOAD → all outputs reset, no flash_write.
- NUM_SECTORS=1, num_blocks=1025 → error on attempt at page 1025 (addr 0x140000).
